// File: rtl/sopc_mem_pkt_pkg.sv
// sopc_mem_pkt_pkg
// Shared definitions for the packet-to-memory writer: default ring geometry,
// FSM state encoding, header word layout and the byte-length helper.
package sopc_mem_pkt_pkg;

    localparam int DEPTH_DEFAULT  = 10750;
    localparam int ADDR_W_DEFAULT = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RSV  = 2'd1,
        ST_DATA = 2'd2,
        ST_HDR  = 2'd3
    } state_t;

    // Header word: {seq, byte_len}
    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_LEN_W   = 16;
    localparam int HDR_SEQ_LSB = 16;
    localparam int HDR_SEQ_W   = 16;

    function automatic logic [31:0] make_hdr(input logic [15:0] seq, input logic [15:0] len);
        logic [31:0] w;
        w = '0;
        w[HDR_SEQ_LSB +: HDR_SEQ_W] = seq;
        w[HDR_LEN_LSB +: HDR_LEN_W] = len;
        return w;
    endfunction

    // prev_beats is the count before the EOP beat; the EOP beat itself is added here.
    function automatic logic [15:0] calc_byte_len(input logic [15:0] prev_beats,
                                                  input logic [1:0]  empty);
        logic [18:0] total;
        total = (19'(prev_beats) + 19'd1) * 19'd4 - 19'(empty);
        return (total > 19'h0FFFF) ? 16'hFFFF : total[15:0];
    endfunction

endpackage

// File: rtl/sopc_ring_ptr_inc.sv
// sopc_ring_ptr_inc
// Modulo-DEPTH increment of a ring word pointer (DEPTH-1 wraps to 0).
//   ptr_i : current pointer
//   ptr_o : next pointer
module sopc_ring_ptr_inc #(
    parameter int DEPTH  = 10750,
    parameter int ADDR_W = 14
) (
    input  logic [ADDR_W-1:0] ptr_i,
    output logic [ADDR_W-1:0] ptr_o
);

    always_comb begin
        if (ptr_i == ADDR_W'(DEPTH - 1)) ptr_o = '0;
        else                             ptr_o = ptr_i + ADDR_W'(1);
    end

endmodule

// File: rtl/sopc_mem_pkt_writer.sv
// sopc_mem_pkt_writer
// Writes Avalon-ST packets into an on-chip memory ring. Each packet takes a
// header word ({seq, byte_len}) followed by its data words; the header is
// written last so the consumer only sees complete packets via commit_ptr.
//   clk, reset                : clock, synchronous active-high reset
//   in_*                      : Avalon-ST sink (data, valid, sop, eop, empty, ready)
//   rd_ptr                    : consumer word pointer, used for the full check
//   commit_ptr, pkt_done      : one past last committed packet, commit pulse
//   drop_count                : beats discarded outside a packet (saturating)
//   address..clken            : registered memory write master
//
// state   | meaning
// IDLE    | waiting for SOP; non-SOP beats are dropped
// RSV     | reserve header slot, stall source one cycle
// DATA    | write beats while ring has space
// HDR     | write header, commit packet
module sopc_mem_pkt_writer
    import sopc_mem_pkt_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [1:0]        in_empty,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W-1:0] commit_ptr,
    output logic              pkt_done,
    output logic [15:0]       drop_count,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [31:0]       writedata,
    output logic              clken
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] hdr_addr_q, hdr_addr_d;
    logic [15:0]       beat_cnt_q, beat_cnt_d;
    logic [15:0]       byte_len_q, byte_len_d;
    logic [15:0]       seq_q, seq_d;
    logic [ADDR_W-1:0] commit_q, commit_d;
    logic [15:0]       drop_q, drop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] wr_ptr_inc;
    logic              space_ok;
    logic              rdy;
    logic              accept;

    sopc_ring_ptr_inc #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wr_inc (
        .ptr_i (wr_ptr_q),
        .ptr_o (wr_ptr_inc)
    );

    // Never let the writer step onto the consumer's next unread word.
    assign space_ok = (wr_ptr_inc != rd_ptr);

    always_comb begin
        rdy = 1'b0;
        case (state_q)
            ST_IDLE: rdy = 1'b1;
            ST_DATA: rdy = space_ok;
            default: rdy = 1'b0;
        endcase
    end

    assign accept = in_valid & rdy;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        hdr_addr_d = hdr_addr_q;
        beat_cnt_d = beat_cnt_q;
        byte_len_d = byte_len_q;
        seq_d      = seq_q;
        commit_d   = commit_q;
        drop_d     = drop_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        cs_d       = 1'b0;
        wr_d       = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_sop) begin
                        // SOP is only observed here; the source keeps it
                        // presented and it is written as the first DATA beat.
                        hdr_addr_d = wr_ptr_q;
                        beat_cnt_d = '0;
                        state_d    = ST_RSV;
                    end else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            ST_RSV: begin
                wr_ptr_d = wr_ptr_inc;
                state_d  = ST_DATA;
            end
            ST_DATA: begin
                if (accept) begin
                    addr_d   = wr_ptr_q;
                    wdata_d  = in_data;
                    be_d     = 4'hF;
                    cs_d     = 1'b1;
                    wr_d     = 1'b1;
                    wr_ptr_d = wr_ptr_inc;
                    if (beat_cnt_q != 16'hFFFF) beat_cnt_d = beat_cnt_q + 16'd1;
                    if (in_eop) begin
                        byte_len_d = calc_byte_len(beat_cnt_q, in_empty);
                        state_d    = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                addr_d   = hdr_addr_q;
                wdata_d  = make_hdr(seq_q, byte_len_q);
                be_d     = 4'hF;
                cs_d     = 1'b1;
                wr_d     = 1'b1;
                commit_d = wr_ptr_q;
                done_d   = 1'b1;
                seq_d    = seq_q + 16'd1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            hdr_addr_q <= '0;
            beat_cnt_q <= '0;
            byte_len_q <= '0;
            seq_q      <= '0;
            commit_q   <= '0;
            drop_q     <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            hdr_addr_q <= hdr_addr_d;
            beat_cnt_q <= beat_cnt_d;
            byte_len_q <= byte_len_d;
            seq_q      <= seq_d;
            commit_q   <= commit_d;
            drop_q     <= drop_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
        end
    end

    assign in_ready   = rdy & ~reset;
    assign commit_ptr = commit_q;
    assign pkt_done   = done_q;
    assign drop_count = drop_q;
    assign address    = addr_q;
    assign byteenable = be_q;
    assign chipselect = cs_q;
    assign write      = wr_q;
    assign writedata  = wdata_q;
    assign clken      = 1'b1;

endmodule

// File: tb/tb_sopc_mem_pkt_writer.sv
module tb_sopc_mem_pkt_writer;

    localparam int DEPTH  = 10750;
    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       in_data;
    logic              in_valid, in_sop, in_eop;
    logic [1:0]        in_empty;
    logic              in_ready;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] commit_ptr;
    logic              pkt_done;
    logic [15:0]       drop_count;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect, write, clken;
    logic [31:0]       writedata;

    sopc_mem_pkt_writer dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_empty   (in_empty),
        .in_ready   (in_ready),
        .rd_ptr     (rd_ptr),
        .commit_ptr (commit_ptr),
        .pkt_done   (pkt_done),
        .drop_count (drop_count),
        .address    (address),
        .byteenable (byteenable),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .clken      (clken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  e;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    bit   trace_en = 0;
    logic ready_trace[$];

    int unsigned m_wr  = 0;
    int unsigned m_seq = 0;

    // Write monitor / scoreboard
    always @(negedge clk) begin
        if (write === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr %0d data %h", address, writedata);
            end else begin
                e = exp_q.pop_front();
                if (address !== e.a || writedata !== e.d || byteenable !== 4'hF || chipselect !== 1'b1) begin
                    errors++;
                    $display("FAIL mem_write actual addr %0d data %h be %h cs %b required addr %0d data %h be f cs 1",
                             address, writedata, byteenable, chipselect, e.a, e.d);
                end
            end
        end
        if (pkt_done === 1'b1) done_cnt++;
        if (trace_en && in_valid) ready_trace.push_back(in_ready);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    function automatic int unsigned minc(input int unsigned p);
        return (p == DEPTH - 1) ? 0 : p + 1;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds a beat until it has seen nacc handshakes (SOP needs two: IDLE peek + DATA write).
    task automatic drive_beat(input logic [31:0] d, input logic s, input logic eo,
                              input logic [1:0] emp, input int nacc);
        int acc;
        int guard;
        acc   = 0;
        guard = 0;
        in_data  = d;
        in_sop   = s;
        in_eop   = eo;
        in_empty = emp;
        in_valid = 1'b1;
        while (acc < nacc && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (in_ready === 1'b1) acc++;
            @(posedge clk);
            #1;
        end
        if (acc < nacc) begin
            errors++;
            $display("FAIL beat_timeout actual %0d accepts required %0d", acc, nacc);
        end
    endtask

    task automatic send_pkt(input int n, input logic [31:0] base, input logic [1:0] emp,
                            input bit keep_valid);
        int unsigned hdr;
        int unsigned p;
        logic [15:0] len;
        hdr = m_wr;
        p   = minc(m_wr);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{a: ADDR_W'(p), d: base + 32'(i)});
            p = minc(p);
        end
        len = 16'(n * 4 - int'(emp));
        exp_q.push_back('{a: ADDR_W'(hdr), d: {m_seq[15:0], len}});
        m_wr = p;
        m_seq++;
        for (int i = 0; i < n; i++)
            drive_beat(base + 32'(i), i == 0, i == n - 1, (i == n - 1) ? emp : 2'd0, (i == 0) ? 2 : 1);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("ready_in_reset", 32'(in_ready), 32'd0);
        cycles(2);
        reset = 1'b0;
        m_wr  = 0;
        m_seq = 0;
        cycles(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_data = '0; in_empty = '0; rd_ptr = '0;
        @(posedge clk); #1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_write",      32'(write),      32'd0);
        chk("rst_chipselect", 32'(chipselect), 32'd0);
        chk("rst_address",    32'(address),    32'd0);
        chk("rst_byteenable", 32'(byteenable), 32'd0);
        chk("rst_writedata",  writedata,       32'd0);
        chk("rst_commit",     32'(commit_ptr), 32'd0);
        chk("rst_drop",       32'(drop_count), 32'd0);
        chk("rst_pkt_done",   32'(pkt_done),   32'd0);
        chk("rst_in_ready",   32'(in_ready),   32'd0);
        chk("clken",          32'(clken),      32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        cycles(1);

        // Non-SOP beats in IDLE are dropped
        drive_beat(32'h77, 1'b0, 1'b0, 2'd0, 1);
        drive_beat(32'h78, 1'b0, 1'b0, 2'd0, 1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("drop_count", 32'(drop_count), 32'd2);
        cycles(1);

        // 3-beat packet, empty=1: data 1..3, header 0x0000000B at 0
        send_pkt(3, 32'hA, 2'd1, 1'b0);
        cycles(3);
        chk("commit_basic", 32'(commit_ptr), 32'd4);
        chk("done_basic", done_cnt, 32'd1);

        // Reset in DATA after 2 beats: partial packet abandoned
        exp_q.push_back('{a: ADDR_W'(5), d: 32'hE0});
        exp_q.push_back('{a: ADDR_W'(6), d: 32'hE1});
        drive_beat(32'hE0, 1'b1, 1'b0, 2'd0, 2);
        drive_beat(32'hE1, 1'b0, 1'b0, 2'd0, 1);
        in_valid = 1'b0;
        do_reset();
        cycles(3);
        chk("commit_after_abort", 32'(commit_ptr), 32'd0);
        chk("done_after_abort", done_cnt, 32'd1);
        send_pkt(1, 32'h55, 2'd0, 1'b0);
        cycles(3);
        chk("commit_post_abort", 32'(commit_ptr), 32'd2);

        // Ring full stall: wr=3 in DATA, rd=5
        rd_ptr = 14'd5;
        exp_q.push_back('{a: ADDR_W'(3), d: 32'hD0});
        exp_q.push_back('{a: ADDR_W'(4), d: 32'hD1});
        exp_q.push_back('{a: ADDR_W'(5), d: 32'hD2});
        exp_q.push_back('{a: ADDR_W'(2), d: 32'h0001000C});
        drive_beat(32'hD0, 1'b1, 1'b0, 2'd0, 2);
        in_valid = 1'b0;
        cycles(2);
        @(negedge clk);
        chk("full_stall", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rd_ptr = 14'd7;
        @(negedge clk);
        chk("full_release", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        drive_beat(32'hD1, 1'b0, 1'b0, 2'd0, 1);
        drive_beat(32'hD2, 1'b0, 1'b1, 2'd0, 1);
        in_valid = 1'b0;
        cycles(3);
        chk("commit_full", 32'(commit_ptr), 32'd6);

        // Back-to-back packets, valid held high
        do_reset();
        rd_ptr   = '0;
        trace_en = 1'b1;
        send_pkt(2, 32'h11, 2'd0, 1'b1);
        send_pkt(3, 32'h33, 2'd3, 1'b0);
        trace_en = 1'b0;
        cycles(3);
        begin
            logic exp_tr[10] = '{1, 0, 1, 1, 0, 1, 0, 1, 1, 1};
            chk("b2b_trace_len", ready_trace.size(), 32'd10);
            for (int i = 0; i < 10 && i < ready_trace.size(); i++)
                chk($sformatf("b2b_ready_%0d", i), 32'(ready_trace[i]), 32'(exp_tr[i]));
        end
        chk("commit_b2b", 32'(commit_ptr), 32'd7);

        // Long packet up to 10748, then a packet wrapping the ring
        do_reset();
        rd_ptr = '0;
        send_pkt(10747, 32'h1000, 2'd0, 1'b0);
        cycles(3);
        chk("commit_long", 32'(commit_ptr), 32'd10748);
        rd_ptr = 14'd5000;
        exp_q.push_back('{a: ADDR_W'(10749), d: 32'hC0});
        exp_q.push_back('{a: ADDR_W'(0),     d: 32'hC1});
        exp_q.push_back('{a: ADDR_W'(1),     d: 32'hC2});
        exp_q.push_back('{a: ADDR_W'(10748), d: 32'h0001000C});
        drive_beat(32'hC0, 1'b1, 1'b0, 2'd0, 2);
        drive_beat(32'hC1, 1'b0, 1'b0, 2'd0, 1);
        drive_beat(32'hC2, 1'b0, 1'b1, 2'd0, 1);
        in_valid = 1'b0;
        cycles(3);
        chk("commit_wrap", 32'(commit_ptr), 32'd2);
        chk("done_total", done_cnt, 32'd7);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
